// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state encoding and widths for the reset sequencer
package reset_seq_pkg;
  typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;
  localparam int LOST_W = 8;
endpackage

// File: rtl/reset_sequencer_sync_n.sv
// sync_n: STAGES-deep flop chain bringing an asynchronous level into the clk domain
module sync_n #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_sync;
  always_ff @(posedge clk) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[STAGES-2:0], i_d};
  end
  assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: holds reset until PLL lock is stable, then releases domains in staggered order
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS    = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 15,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   locked_async,
  input  logic                   sw_req,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   ready,
  output logic [LOST_W-1:0]      lock_lost_count
);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam int SW = STAGGER_CYCLES > 1 ? $clog2(STAGGER_CYCLES) : 1;
  localparam int DW = NUM_DOMAINS > 1 ? $clog2(NUM_DOMAINS) : 1;
  state_t                 r_state;
  logic [HW-1:0]          r_hold;
  logic [SW-1:0]          r_stg;
  logic [DW-1:0]          r_dom;
  logic [NUM_DOMAINS-1:0] r_rst;
  logic                   r_ready;
  logic [LOST_W-1:0]      r_lost;
  logic                   w_locked_s;
  logic                   w_abort;
  sync_n #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (locked_async),
    .o_q   (w_locked_s)
  );
  assign w_abort = !w_locked_s || sw_req;
  // r_dom names the next domain to release; domain 0 is released on leaving HOLD
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= HOLD;
      r_hold  <= '0;
      r_stg   <= '0;
      r_dom   <= '0;
      r_rst   <= '1;
      r_ready <= 1'b0;
      r_lost  <= '0;
    end else if (r_state != HOLD && w_abort) begin
      r_state <= HOLD;
      r_hold  <= '0;
      r_stg   <= '0;
      r_dom   <= '0;
      r_rst   <= '1;
      r_ready <= 1'b0;
      if (!w_locked_s && r_lost != '1) r_lost <= r_lost + 1'b1;
    end else begin
      case (r_state)
        HOLD: begin
          if (w_abort) r_hold <= '0;
          else if (r_hold == HW'(HOLD_CYCLES-1)) begin
            r_hold <= '0;
            r_stg  <= '0;
            if (NUM_DOMAINS == 1) begin
              r_state <= RUN;
              r_rst   <= '0;
            end else begin
              r_state  <= RELEASE;
              r_rst[0] <= 1'b0;
              r_dom    <= DW'(1);
            end
          end else r_hold <= r_hold + 1'b1;
        end
        RELEASE: begin
          if (r_stg == SW'(STAGGER_CYCLES-1)) begin
            r_stg        <= '0;
            r_rst[r_dom] <= 1'b0;
            if (r_dom == DW'(NUM_DOMAINS-1)) r_state <= RUN;
            else r_dom <= r_dom + 1'b1;
          end else r_stg <= r_stg + 1'b1;
        end
        default: r_ready <= 1'b1;
      endcase
    end
  end
  assign rst_out         = r_rst;
  assign ready           = r_ready;
  assign lock_lost_count = r_lost;
endmodule
